// File: rtl/avl_bus_arbiter_if.sv
// Signal bundle between the two core requesters, the arbiter and the Avalon-MM master port.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface avl_bus_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  i_read_i;
    logic [ADDR_WIDTH-1:0] i_addr_i;
    logic [DATA_WIDTH-1:0] i_rdata_o;
    logic                  i_rvalid_o;
    logic                  i_wait_o;

    logic                  d_read_i;
    logic                  d_write_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic [BE_WIDTH-1:0]   d_be_i;
    logic [DATA_WIDTH-1:0] d_rdata_o;
    logic                  d_rvalid_o;
    logic                  d_wait_o;

    logic [ADDR_WIDTH-1:0] avm_address_o;
    logic                  avm_read_o;
    logic                  avm_write_o;
    logic [DATA_WIDTH-1:0] avm_writedata_o;
    logic [BE_WIDTH-1:0]   avm_byteenable_o;
    logic [DATA_WIDTH-1:0] avm_readdata_i;
    logic                  avm_waitrequest_i;
    logic                  avm_readdatavalid_i;

    modport master (
        input  i_read_i, i_addr_i,
        output i_rdata_o, i_rvalid_o, i_wait_o,
        input  d_read_i, d_write_i, d_addr_i, d_wdata_i, d_be_i,
        output d_rdata_o, d_rvalid_o, d_wait_o,
        output avm_address_o, avm_read_o, avm_write_o, avm_writedata_o, avm_byteenable_o,
        input  avm_readdata_i, avm_waitrequest_i, avm_readdatavalid_i
    );

    modport slave (
        output i_read_i, i_addr_i,
        input  i_rdata_o, i_rvalid_o, i_wait_o,
        output d_read_i, d_write_i, d_addr_i, d_wdata_i, d_be_i,
        input  d_rdata_o, d_rvalid_o, d_wait_o,
        input  avm_address_o, avm_read_o, avm_write_o, avm_writedata_o, avm_byteenable_o,
        output avm_readdata_i, avm_waitrequest_i, avm_readdatavalid_i
    );
endinterface

// File: rtl/avl_bus_arbiter.sv
// Shares one Avalon-MM master between instruction fetch (I) and load/store (D) requesters,
// one outstanding transfer at a time, round-robin on ties.
module avl_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    avl_bus_arbiter_if.master bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    state_t                state;
    port_t                 owner;
    port_t                 last_grant;
    logic                  abandoned;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [BE_WIDTH-1:0]   cmd_be;
    logic                  cmd_read;
    logic                  cmd_write;

    logic d_req;
    logic grant_d;
    logic owner_req;
    logic read_done;
    logic write_done;
    logic owner_done;

    assign d_req      = bus.d_read_i | bus.d_write_i;
    assign grant_d    = d_req && (!bus.i_read_i || last_grant == PORT_I);
    assign owner_req  = (owner == PORT_D) ? d_req : bus.i_read_i;
    assign read_done  = (state == RESP) && bus.avm_readdatavalid_i;
    assign write_done = (state == CMD) && cmd_write && !bus.avm_waitrequest_i;
    // A requester that let go mid-transfer must not see the completion, even if it re-requests.
    assign owner_done = (read_done || write_done) && owner_req && !abandoned;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            owner      <= PORT_I;
            last_grant <= PORT_I;
            abandoned  <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_be     <= '0;
            cmd_read   <= 1'b0;
            cmd_write  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    abandoned <= 1'b0;
                    if (d_req || bus.i_read_i) begin
                        state      <= CMD;
                        owner      <= grant_d ? PORT_D : PORT_I;
                        last_grant <= grant_d ? PORT_D : PORT_I;
                        if (grant_d) begin
                            cmd_addr  <= bus.d_addr_i;
                            cmd_wdata <= bus.d_wdata_i;
                            cmd_be    <= bus.d_be_i;
                            cmd_write <= bus.d_write_i;
                            cmd_read  <= !bus.d_write_i;
                        end else begin
                            cmd_addr  <= bus.i_addr_i;
                            cmd_wdata <= '0;
                            cmd_be    <= '1;
                            cmd_write <= 1'b0;
                            cmd_read  <= 1'b1;
                        end
                    end
                end
                CMD: begin
                    if (!owner_req) abandoned <= 1'b1;
                    if (!bus.avm_waitrequest_i) begin
                        state     <= cmd_write ? IDLE : RESP;
                        cmd_addr  <= '0;
                        cmd_wdata <= '0;
                        cmd_be    <= '0;
                        cmd_read  <= 1'b0;
                        cmd_write <= 1'b0;
                    end
                end
                RESP: begin
                    if (!owner_req) abandoned <= 1'b1;
                    if (bus.avm_readdatavalid_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.avm_address_o    = cmd_addr;
    assign bus.avm_read_o       = cmd_read;
    assign bus.avm_write_o      = cmd_write;
    assign bus.avm_writedata_o  = cmd_wdata;
    assign bus.avm_byteenable_o = cmd_be;

    assign bus.i_rvalid_o = read_done && owner_done && owner == PORT_I;
    assign bus.d_rvalid_o = read_done && owner_done && owner == PORT_D;
    assign bus.i_rdata_o  = bus.i_rvalid_o ? bus.avm_readdata_i : '0;
    assign bus.d_rdata_o  = bus.d_rvalid_o ? bus.avm_readdata_i : '0;
    assign bus.i_wait_o   = bus.i_read_i && !(owner_done && owner == PORT_I);
    assign bus.d_wait_o   = d_req && !(owner_done && owner == PORT_D);
endmodule

// File: tb/tb_avl_bus_arbiter.sv
// Scoreboarded bench for avl_bus_arbiter: directed scenarios then randomized traffic against
// a word-addressed memory model and an Avalon slave with random waitrequest/readdatavalid timing.
module tb_avl_bus_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    avl_bus_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    avl_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk_i(clk), .reset_i(reset_i), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents: a fixed function of address until written.
    logic [31:0] slave_mem [int unsigned];
    logic [31:0] ref_mem   [int unsigned];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int unsigned k = a >> 2;
        return ref_mem.exists(k) ? ref_mem[k] : init_word({a[31:2], 2'b00});
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        int unsigned k = a >> 2;
        return slave_mem.exists(k) ? slave_mem[k] : init_word({a[31:2], 2'b00});
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        slave_mem[a >> 2] = d;
        ref_mem[a >> 2]   = d;
    endtask

    logic [31:0] i_exp_q[$];
    logic [31:0] d_exp_q[$];
    bit          grant_log[$];
    int          rvalid_seen = 0;
    int          read_hi = 0;

    // Avalon slave model knobs
    int wait_lo = 0, wait_hi = 0, lat_lo = 0, lat_hi = 0;
    bit stray_en = 0;

    initial begin : slave_model
        bit          in_cmd = 0;
        bit          resp_pend = 0;
        int          wait_left = 0;
        int          resp_delay = 0;
        logic [31:0] resp_data = '0;
        bus.avm_readdata_i      = '0;
        bus.avm_waitrequest_i   = 1'b0;
        bus.avm_readdatavalid_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_i && (bus.avm_read_o || bus.avm_write_o) && !bus.avm_waitrequest_i) begin
                if (bus.avm_write_o)
                    slave_mem[bus.avm_address_o >> 2] = merge(slave_rd(bus.avm_address_o),
                                                              bus.avm_writedata_o, bus.avm_byteenable_o);
                else begin
                    resp_pend  = 1;
                    resp_delay = $urandom_range(lat_hi, lat_lo);
                    resp_data  = slave_rd(bus.avm_address_o);
                end
            end
            @(posedge clk);
            #1;
            bus.avm_readdatavalid_i = 1'b0;
            bus.avm_readdata_i      = $urandom;
            if (resp_pend) begin
                if (resp_delay == 0) begin
                    bus.avm_readdatavalid_i = 1'b1;
                    bus.avm_readdata_i      = resp_data;
                    resp_pend = 0;
                end else resp_delay--;
            end else if (stray_en && $urandom_range(7, 0) == 0) bus.avm_readdatavalid_i = 1'b1;
            if (!reset_i && (bus.avm_read_o || bus.avm_write_o)) begin
                if (!in_cmd) begin
                    in_cmd    = 1;
                    wait_left = $urandom_range(wait_hi, wait_lo);
                end else if (wait_left > 0) wait_left--;
                bus.avm_waitrequest_i = (wait_left > 0);
            end else begin
                in_cmd = 0;
                bus.avm_waitrequest_i = 1'($urandom_range(1, 0));
            end
        end
    end

    // Monitor: pops the scoreboard on every rvalid and checks command stability under waitrequest.
    initial begin : monitor
        logic [69:0] prev_cmd_bits = '0;
        logic [69:0] cur_cmd_bits;
        bit          prev_active = 0;
        bit          prev_wreq = 0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                prev_active = 0;
                prev_wreq   = 0;
            end else begin
                cur_cmd_bits = {bus.avm_address_o, bus.avm_writedata_o, bus.avm_byteenable_o,
                                bus.avm_read_o, bus.avm_write_o};
                if (prev_active && prev_wreq) check("cmd_hold", cur_cmd_bits, prev_cmd_bits);
                if ((bus.avm_read_o || bus.avm_write_o) && !prev_active)
                    grant_log.push_back(bus.avm_address_o[29]);
                if (bus.avm_read_o) read_hi++;
                if (bus.i_rvalid_o) begin
                    rvalid_seen++;
                    if (i_exp_q.size() == 0) check("i_rvalid_unexpected", bus.i_rvalid_o, 0);
                    else check("i_rdata", bus.i_rdata_o, i_exp_q.pop_front());
                    check("d_rdata_nonowner", bus.d_rdata_o, 0);
                    check("i_wait_on_rvalid", bus.i_wait_o, 0);
                    if (bus.d_read_i || bus.d_write_i) check("d_wait_held", bus.d_wait_o, 1);
                end
                if (bus.d_rvalid_o) begin
                    rvalid_seen++;
                    if (d_exp_q.size() == 0) check("d_rvalid_unexpected", bus.d_rvalid_o, 0);
                    else check("d_rdata", bus.d_rdata_o, d_exp_q.pop_front());
                    check("i_rdata_nonowner", bus.i_rdata_o, 0);
                    check("d_wait_on_rvalid", bus.d_wait_o, 0);
                    if (bus.i_read_i) check("i_wait_held", bus.i_wait_o, 1);
                end
                prev_cmd_bits = cur_cmd_bits;
                prev_active   = bus.avm_read_o || bus.avm_write_o;
                prev_wreq     = bus.avm_waitrequest_i;
            end
        end
    end

    // NOTE: bench inputs are driven with blocking assignments #1 after the edge, outputs sampled at negedge.
    task automatic i_txn(input logic [31:0] addr, output int cycles, output bit aborted);
        bit done = 0;
        bus.i_read_i = 1'b1;
        bus.i_addr_i = addr;
        i_exp_q.push_back(ref_rd(addr));
        cycles  = 0;
        aborted = 0;
        while (!done) begin
            @(negedge clk);
            cycles++;
            if (reset_i) begin
                aborted = 1;
                done    = 1;
            end else if (!bus.i_wait_o) begin
                check("i_done_rvalid", bus.i_rvalid_o, 1);
                done = 1;
            end else if (cycles >= 200) begin
                check("i_timeout", bus.i_wait_o, 0);
                aborted = 1;
                done    = 1;
            end
        end
        @(posedge clk);
        #1;
        bus.i_read_i = 1'b0;
        bus.i_addr_i = $urandom;
    endtask

    // op: 0 load, 1 store, 2 load+store (store wins)
    task automatic d_txn(input logic [31:0] addr, input int op, input logic [31:0] wd, input logic [3:0] be,
                         output int cycles, output bit aborted);
        bit done = 0;
        bit is_wr = (op != 0);
        bus.d_read_i  = (op != 1);
        bus.d_write_i = is_wr;
        bus.d_addr_i  = addr;
        bus.d_wdata_i = wd;
        bus.d_be_i    = be;
        if (is_wr) ref_mem[addr >> 2] = merge(ref_rd(addr), wd, be);
        else d_exp_q.push_back(ref_rd(addr));
        cycles  = 0;
        aborted = 0;
        while (!done) begin
            @(negedge clk);
            cycles++;
            if (reset_i) begin
                aborted = 1;
                done    = 1;
            end else if (!bus.d_wait_o) begin
                if (is_wr)
                    check("d_wr_done", {bus.avm_write_o, bus.avm_read_o, bus.avm_waitrequest_i, bus.d_rvalid_o}, 4'b1000);
                else check("d_done_rvalid", bus.d_rvalid_o, 1);
                done = 1;
            end else if (cycles >= 200) begin
                check("d_timeout", bus.d_wait_o, 0);
                aborted = 1;
                done    = 1;
            end
        end
        @(posedge clk);
        #1;
        bus.d_read_i  = 1'b0;
        bus.d_write_i = 1'b0;
        bus.d_addr_i  = $urandom;
        bus.d_wdata_i = $urandom;
        bus.d_be_i    = 4'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avm"}, {bus.avm_address_o, bus.avm_read_o, bus.avm_write_o,
                              bus.avm_writedata_o, bus.avm_byteenable_o}, 0);
        check({tag, "_resp"}, {bus.i_rvalid_o, bus.d_rvalid_o, bus.i_rdata_o, bus.d_rdata_o}, 0);
    endtask

    task automatic do_reset();
        reset_i       = 1'b1;
        bus.i_read_i  = 1'b0;
        bus.d_read_i  = 1'b0;
        bus.d_write_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        i_exp_q.delete();
        d_exp_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c1, c2, g0, r0;
        bit a1, a2;
        bus.i_addr_i  = '0;
        bus.d_addr_i  = '0;
        bus.d_wdata_i = '0;
        bus.d_be_i    = '0;
        do_reset();

        // I-port fetch, no waitrequest, data two cycles after the command
        wait_lo = 0; wait_hi = 0; lat_lo = 1; lat_hi = 1;
        preload(32'h0000_0100, 32'h0000_0013);
        r0 = read_hi;
        i_txn(32'h0000_0100, c1, a1);
        check("t1_cycles", c1, 4);
        check("t1_read_hi_cycles", read_hi - r0, 1);

        // D-port store held off by three waitrequest cycles
        wait_lo = 3; wait_hi = 3;
        d_txn(32'h2000_0002, 1, 32'h00AB_0000, 4'b0100, c1, a1);
        check("t2_cycles", c1, 5);
        check("t2_mem", slave_rd(32'h2000_0000), ref_rd(32'h2000_0000));

        // Both ports requesting back-to-back from reset: grants D,I,D,I
        do_reset();
        wait_lo = 0; wait_hi = 0; lat_lo = 0; lat_hi = 0;
        g0 = grant_log.size();
        fork
            begin d_txn(32'h2000_0004, 0, 0, 4'hF, c1, a1); d_txn(32'h2000_0008, 0, 0, 4'hF, c1, a1); end
            begin i_txn(32'h0000_1000, c2, a2); i_txn(32'h0000_1004, c2, a2); end
        join
        check("t3_grant_count", grant_log.size() - g0, 4);
        for (int k = 0; k < 4 && g0 + k < grant_log.size(); k++)
            check($sformatf("t3_grant%0d", k), grant_log[g0 + k], (k % 2 == 0));

        // D load in flight while the I-port waits; I is granted next
        preload(32'h2000_0040, 32'hDEAD_BEEF);
        lat_lo = 3; lat_hi = 3;
        g0 = grant_log.size();
        fork
            d_txn(32'h2000_0040, 0, 0, 4'hF, c1, a1);
            begin repeat (2) @(posedge clk); #1; i_txn(32'h0000_1010, c2, a2); end
        join
        check("t4_grant_count", grant_log.size() - g0, 2);
        if (grant_log.size() >= g0 + 2) begin
            check("t4_grant_first", grant_log[g0], 1);
            check("t4_grant_second", grant_log[g0 + 1], 0);
        end

        // Reset while waiting for read data; the late readdatavalid must be ignored
        lat_lo = 6; lat_hi = 6;
        r0 = rvalid_seen;
        fork
            d_txn(32'h2000_0010, 0, 0, 4'hF, c1, a1);
            begin
                repeat (3) @(posedge clk);
                #3 reset_i = 1'b1;
                #1 check_reset_outputs("t5_in_reset");
                repeat (2) @(posedge clk);
                #3 reset_i = 1'b0;
            end
        join
        check("t5_aborted", a1, 1);
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_rvalid", rvalid_seen - r0, 0);
        d_exp_q.delete();

        // Load and store both asserted: store wins, then read it back
        lat_lo = 0; lat_hi = 0; wait_lo = 1; wait_hi = 1;
        d_txn(32'h0000_0010, 2, 32'hCAFE_F00D, 4'hF, c1, a1);
        d_txn(32'h0000_0010, 0, 0, 4'hF, c1, a1);

        // Randomized mixed traffic
        wait_lo = 0; wait_hi = 3; lat_lo = 0; lat_hi = 3; stray_en = 1;
        fork
            begin
                int ci; bit ai;
                for (int k = 0; k < 150; k++) begin
                    repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
                    i_txn(32'h0000_1000 + 4 * $urandom_range(63, 0), ci, ai);
                end
            end
            begin
                int cd; bit ad;
                for (int k = 0; k < 150; k++) begin
                    repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
                    d_txn(32'h2000_0000 + 4 * $urandom_range(7, 0), int'($urandom_range(2, 0)),
                          $urandom, 4'($urandom_range(15, 1)), cd, ad);
                end
            end
        join
        stray_en = 0;
        repeat (5) @(posedge clk);
        #1;
        check("i_queue_drained", i_exp_q.size(), 0);
        check("d_queue_drained", d_exp_q.size(), 0);
        foreach (ref_mem[k])
            check($sformatf("mem_word_%0h", k), slave_mem.exists(k) ? slave_mem[k] : init_word(k << 2), ref_mem[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
